mult_seq: RTL and testbench

Parametrised iterative shift-add multiplier; successor to the fixed 8x8 `mult16` block used in the NN datapath. Takes two WIDTH-bit operands through a valid/ready handshake, computes the 2*WIDTH-bit product over WIDTH clock cycles, and holds the result until the consumer accepts it. Optional two's-complement mode. Serves as the multiplier stage of the neuron MAC pipeline, where area outweighs throughput.

---
 rtl/mult_pkg.sv | 15 +
 rtl/mult_seq_dp.sv | 60 ++++++
 rtl/mult_seq.sv | 86 ++++++++
 tb/tb_mult_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Counter width able to hold 0..width.
  function automatic int mult_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_seq_dp.sv
// Shift-add datapath: operand latch, accumulator, adder/shifter and sign fix-up.
// Two's-complement handling is built only when MULT_SIGNED_EN is defined.
module mult_seq_dp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_result
);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

`ifdef MULT_SIGNED_EN
  logic r_neg;

  // The most negative value negates to 2^(WIDTH-1), still exact as unsigned.
  assign w_mag_a = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
  assign w_mag_b = i_b[WIDTH-1] ? (~i_b + 1'b1) : i_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_neg <= 1'b0;
    end else if (i_load) begin
      r_neg <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
    end
  end

  assign o_result = r_neg ? (~r_acc + 1'b1) : r_acc;
`else
  assign w_mag_a  = i_a;
  assign w_mag_b  = i_b;
  assign o_result = r_acc;
`endif

  assign w_addend = r_acc[0] ? r_mcand : '0;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand <= '0;
      r_acc   <= '0;
    end else if (i_load) begin
      r_mcand <= w_mag_a;
      r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
    end else if (i_step) begin
      // Carry lands in the MSB as {carry, acc} shifts right by one.
      r_acc <= {w_sum, r_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_seq.sv
// Iterative multiplier top: valid/ready handshake FSM and iteration counter.
// Define MULT_SIGNED_EN for two's-complement operands and result.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = mult_cnt_w(WIDTH);

  mult_state_t   r_state;
  mult_state_t   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_load;
  logic          w_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_step = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  mult_seq_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_a     (multiplicand),
    .i_b     (multiplier),
    .o_result(result)
  );

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq (WIDTH=8 and WIDTH=16 instances).
// Follows MULT_SIGNED_EN for the reference model and signed cases.
module tb_mult_seq;

  localparam int W  = 8;
  localparam int W2 = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] result;

  logic            in_valid16, in_ready16, out_valid16, out_ready16;
  logic [W2-1:0]   a16, b16;
  logic [2*W2-1:0] result16;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(a), .multiplier(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  mult_seq #(.WIDTH(W2)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .multiplicand(a16), .multiplier(b16), .out_valid(out_valid16),
    .out_ready(out_ready16), .result(result16)
  );

  // Reference: interpret operands per mode, multiply as integers, keep 2w bits.
  function automatic longint sext(input longint v, input int w);
`ifdef MULT_SIGNED_EN
    if (v >= (longint'(1) << (w - 1))) return v - (longint'(1) << w);
`endif
    return v;
  endfunction

  function automatic longint model(input longint x, input longint y, input int w);
    longint p;
    p = sext(x, w) * sext(y, w);
    return p & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic op8(input logic [W-1:0] ia, input logic [W-1:0] ib,
                     output logic [2*W-1:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(posedge clk); #1; lat++;
    end
    res = result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [2*W-1:0] r;
    int lat;
    op8(8'd3, 8'd5, r, lat);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++;
    if (result !== '0) begin n_fail++; $display("FAIL reset_result got %h exp 0", result); end
  endtask

  task automatic test_basic();
    logic [2*W-1:0] r;
    int lat;
    logic [W-1:0] ops [4] = '{8'd2, 8'd2, 8'd10, 8'd10};
    for (int i = 0; i < 4; i += 2) begin
      op8(ops[i], ops[i+1], r, lat);
      n_cmp++;
      if (r !== (2*W)'(model(ops[i], ops[i+1], W))) begin
        n_fail++; $display("FAIL basic_result %0d*%0d got %h exp %h", ops[i], ops[i+1], r,
                           (2*W)'(model(ops[i], ops[i+1], W)));
      end
      n_cmp++;
      if (lat !== W) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", lat, W); end
    end
  endtask

  task automatic test_corners();
    logic [2*W-1:0] r;
    int lat;
    op8(8'd255, 8'd255, r, lat);
    n_cmp++;
    if (r !== (2*W)'(model(255, 255, W))) begin
      n_fail++; $display("FAIL corner_max got %h exp %h", r, (2*W)'(model(255, 255, W)));
    end
    op8(8'd0, 8'd173, r, lat);
    n_cmp++;
    if (r !== '0) begin n_fail++; $display("FAIL corner_zero got %h exp 0", r); end
    n_cmp++;
    if (lat !== W) begin n_fail++; $display("FAIL corner_zero_latency got %0d exp %0d", lat, W); end

    a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 4 * W2) begin
      @(posedge clk); #1; lat++;
    end
    n_cmp++;
    if (result16 !== (2*W2)'(model(65535, 65535, W2))) begin
      n_fail++; $display("FAIL corner_w16 got %h exp %h", result16, (2*W2)'(model(65535, 65535, W2)));
    end
    n_cmp++;
    if (lat !== W2) begin n_fail++; $display("FAIL corner_w16_latency got %0d exp %0d", lat, W2); end
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] expv;
    int lat;
    expv = (2*W)'(model(200, 3, W));
    a = 8'd200; b = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(posedge clk); #1; lat++;
    end
    a = 8'd17; b = 8'd19; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== expv) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got v=%b r=%b res=%h exp v=1 r=0 res=%h",
                 i, out_valid, in_ready, result, expv);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL release got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL no_stray_accept got %b exp 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [2*W-1:0] r;
    int lat;
    a = 8'd99; b = 8'd77; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
    end
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_stray_valid got %b exp 0", out_valid); end
    end
    op8(8'd7, 8'd9, r, lat);
    n_cmp++;
    if (r !== 16'd63) begin n_fail++; $display("FAIL after_reset_op got %h exp %h", r, 16'd63); end
    n_cmp++;
    if (lat !== W) begin n_fail++; $display("FAIL after_reset_latency got %0d exp %0d", lat, W); end
  endtask

  task automatic test_random();
    logic [2*W-1:0] r;
    logic [W-1:0] x, y;
    int lat;
    for (int i = 0; i < 24; i++) begin
      x = W'($urandom); y = W'($urandom);
      op8(x, y, r, lat);
      n_cmp++;
      if (r !== (2*W)'(model(x, y, W)) || lat !== W) begin
        n_fail++;
        $display("FAIL random %h*%h got %h lat %0d exp %h lat %0d", x, y, r, lat,
                 (2*W)'(model(x, y, W)), W);
      end
    end
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed();
    logic [2*W-1:0] r;
    int lat;
    logic [W-1:0]   sa [3] = '{8'h80, 8'hFD, 8'h7F};
    logic [W-1:0]   sb [3] = '{8'h80, 8'h05, 8'h80};
    logic [2*W-1:0] se [3] = '{16'h4000, 16'hFFF1, 16'hC080};
    for (int i = 0; i < 3; i++) begin
      op8(sa[i], sb[i], r, lat);
      n_cmp++;
      if (r !== se[i] || lat !== W) begin
        n_fail++;
        $display("FAIL signed %h*%h got %h lat %0d exp %h lat %0d", sa[i], sb[i], r, lat, se[i], W);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef MULT_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
